// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver, 2-flop rx synchroniser, start-bit validation and mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy,
  output logic [2:0]           state_dbg
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  // Output contract: rx_valid / frame_err / parity_err are single-cycle strobes with no
  // back-pressure; rx_data is stable from the rx_valid cycle until the next rx_valid.
  logic                 rx_meta_q, rx_s_q;
  state_t               state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    bcnt_d      = bcnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (sample_tick && !rx_s_q) begin
          state_d = S_START;
          tcnt_d  = '0;
        end
      end
      S_START: begin
        if (sample_tick) begin
          if (tcnt_q == T_MID) begin
            // A start bit still low at its centre is genuine; anything else was a glitch.
            if (!rx_s_q) begin
              state_d = S_DATA;
              tcnt_d  = '0;
              bcnt_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (sample_tick) begin
          if (tcnt_q == T_END) begin
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            tcnt_d  = '0;
            if (bcnt_q == B_LAST) begin
              bcnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (sample_tick) begin
          if (tcnt_q == T_END) begin
            par_bad_d = rx_s_q ^ (^shreg_q);
            tcnt_d    = '0;
            state_d   = S_STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (sample_tick) begin
          if (tcnt_q == T_END) begin
            tcnt_d = '0;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
            if (rx_s_q) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
              state_d    = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_BREAK;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      bcnt_q      <= bcnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed vector table, corner-case sequences and random frames
// checked against a frame-level reference model through an expected-event queue.
module tb_uart_rx_ctrl;
  localparam int DB = 8;
  localparam int OS = 16;
  localparam int EW = 3 + DB + 1;
  localparam logic [2:0] K_V  = 3'b001;
  localparam logic [2:0] K_F  = 3'b010;
  localparam logic [2:0] K_VP = 3'b101;

  typedef struct packed {
    logic [2:0]    kind;
    logic [DB-1:0] data;
    logic          busy;
  } ev_t;

  typedef struct {
    logic [DB-1:0] d;
    logic          stop;
    logic          pflip;
    int            gap;
    logic [2:0]    ek;
    logic [DB-1:0] ed;
  } vec_t;

  logic          sys_clk = 1'b0;
  logic          rst;
  logic          sample_tick;
  logic          rx;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, parity_err, busy;
  logic [2:0]    state_dbg;

  int checks   = 0;
  int failures = 0;
  int max_gap  = 0;

  logic [EW-1:0] exp_q[$];
  ev_t           obs_mem[256];
  int            obs_wr = 0;
  int            obs_rd = 0;
  logic [DB-1:0] last_good = '0;
  vec_t          vecs[$];

  uart_rx_ctrl #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .sample_tick(sample_tick),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Clock / watchdog
  initial forever #5 sys_clk = ~sys_clk;

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Monitor: log every strobe cycle with the outputs seen alongside it
  always @(negedge sys_clk) begin
    if (rx_valid || frame_err || parity_err) begin
      if (obs_wr < 256) obs_mem[obs_wr] <= {parity_err, frame_err, rx_valid, rx_data, busy};
      obs_wr <= obs_wr + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Driver tasks: every input change happens on a falling edge
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk) sample_tick = 1'b1;
      @(negedge sys_clk) sample_tick = 1'b0;
      repeat ($urandom_range(0, max_gap)) @(negedge sys_clk);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick_n(OS);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic pflip);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ pflip);
`endif
    send_bit(stop);
  endtask

  // Scoreboard: compare logged strobes against the expected queue
  task automatic drain(input string name);
    ev_t e, o;
    repeat (4) @(negedge sys_clk);
    chk({name, ".count"}, obs_wr - obs_rd, exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_wr && obs_rd < 256) begin
        o = obs_mem[obs_rd];
        obs_rd++;
        chk({name, ".kind"}, o.kind, e.kind);
        chk({name, ".data"}, o.data, e.data);
        chk({name, ".busy"}, o.busy, e.busy);
      end
    end
    obs_rd = obs_wr;
    chk({name, ".hold"}, rx_data, last_good);
  endtask

  task automatic run_frame(input logic [DB-1:0] d, input logic stop, input logic pflip,
                           input int gap, input ev_t e, input string name);
    exp_q.push_back(e);
    send_frame(d, stop, pflip);
    if (!stop) begin
      rx = 1'b0;
      tick_n(3 * OS);
      chk({name, ".break_busy"}, busy, 1);
      rx = 1'b1;
      tick_n(2);
      chk({name, ".break_exit"}, busy, 0);
    end
    rx = 1'b1;
    tick_n(gap);
    drain(name);
  endtask

  // Reference model: outcome of a frame from its bits alone
  function automatic ev_t model(input logic [DB-1:0] d, input logic stop, input logic pflip);
    ev_t e;
    logic perr;
`ifdef UART_RX_PARITY_EN
    perr = pflip;
`else
    perr = 1'b0;
`endif
    e.kind = {perr, !stop, stop};
    e.data = stop ? d : last_good;
    e.busy = !stop;
    return e;
  endfunction

  function automatic void add_vec(input logic [DB-1:0] d, input logic stop, input logic pflip,
                                  input int gap, input logic [2:0] ek, input logic [DB-1:0] ed);
    vec_t v;
    v.d = d; v.stop = stop; v.pflip = pflip; v.gap = gap; v.ek = ek; v.ed = ed;
    vecs.push_back(v);
  endfunction

  initial begin
    ev_t           e;
    logic [DB-1:0] d;
    logic          stop, pflip;

    add_vec(8'hA5, 1'b1, 1'b0, 4, K_V, 8'hA5);
    add_vec(8'h3C, 1'b0, 1'b0, 4, K_F, 8'hA5);
    add_vec(8'h00, 1'b1, 1'b0, 0, K_V, 8'h00);
    add_vec(8'hFF, 1'b1, 1'b0, 2, K_V, 8'hFF);
    add_vec(8'h81, 1'b1, 1'b0, 0, K_V, 8'h81);
    add_vec(8'h7E, 1'b0, 1'b0, 2, K_F, 8'h81);
    add_vec(8'h01, 1'b1, 1'b0, 3, K_V, 8'h01);
`ifdef UART_RX_PARITY_EN
    add_vec(8'h07, 1'b1, 1'b0, 3, K_V,  8'h07);
    add_vec(8'h07, 1'b1, 1'b1, 3, K_VP, 8'h07);
`endif

    // Reset
    rst = 1'b1; rx = 1'b1; sample_tick = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst.rx_data", rx_data, 0);
    chk("rst.rx_valid", rx_valid, 0);
    chk("rst.frame_err", frame_err, 0);
    chk("rst.parity_err", parity_err, 0);
    chk("rst.busy", busy, 0);
    chk("rst.state", state_dbg, 0);
    rst = 1'b0;
    tick_n(100);
    chk("idle.strobes", obs_wr, 0);
    chk("idle.busy", busy, 0);
    obs_rd = obs_wr;

    // Directed vector table
    foreach (vecs[i]) begin
      e.kind = vecs[i].ek;
      e.data = vecs[i].ed;
      e.busy = vecs[i].ek[1];
      if (vecs[i].ek[0]) last_good = vecs[i].ed;
      run_frame(vecs[i].d, vecs[i].stop, vecs[i].pflip, vecs[i].gap, e, $sformatf("vec%0d", i));
    end

    // Glitch: four low ticks are not a start bit
    rx = 1'b0;
    tick_n(4);
    chk("glitch.busy_rise", busy, 1);
    rx = 1'b1;
    tick_n(20);
    chk("glitch.busy_fall", busy, 0);
    drain("glitch");

    // Back-to-back 0x00 then 0xFF
    last_good = 8'h00;
    exp_q.push_back({K_V, 8'h00, 1'b0});
    send_frame(8'h00, 1'b1, 1'b0);
    last_good = 8'hFF;
    exp_q.push_back({K_V, 8'hFF, 1'b0});
    send_frame(8'hFF, 1'b1, 1'b0);
    rx = 1'b1;
    tick_n(2);
    drain("b2b");

    // Reset during bit 3 of a third frame discards it and clears rx_data
    rx = 1'b0; tick_n(OS);
    d = 8'h96;
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    rx = d[3];
    tick_n(OS / 2);
    @(negedge sys_clk) rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    last_good = '0;
    chk("midrst.rx_data", rx_data, 0);
    chk("midrst.busy", busy, 0);
    tick_n(OS);
    drain("midrst");
    last_good = 8'h5A;
    run_frame(8'h5A, 1'b1, 1'b0, 2, '{kind: K_V, data: 8'h5A, busy: 1'b0}, "after_rst");

    // Random frames against the model, with jittered tick spacing
    max_gap = 2;
    for (int i = 0; i < 20; i++) begin
      d     = DB'($urandom);
      stop  = ($urandom_range(0, 3) != 0);
      pflip = 1'($urandom_range(0, 1));
      e     = model(d, stop, pflip);
      if (stop) last_good = d;
      run_frame(d, stop, pflip, $urandom_range(0, 3), e, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
